maxpool_scheduler: RTL
======================

Name: maxpool_scheduler

Overview:
Sequences a multi-channel max-pool layer through one shared maxpool_engine instance. The block does the following for each channel in order:
- reads the channel's MAP_WIDTH x MAP_WIDTH feature map from an input feature RAM (1-cycle synchronous read),
- streams it into the engine,
- clears the engine between channels,
- writes the OUT_DIM x OUT_DIM pooled results to an output RAM.

It sits between the conv-layer output buffer and the next layer's input buffer.

Parameters:
- MAP_WIDTH, 28, input map side length (even).
- OUT_DIM, MAP_WIDTH/2, pooled map side length.
- NUM_CH, 6, number of channels pooled per start.
- IN_AW, $clog2(NUM_CH*MAP_WIDTH*MAP_WIDTH), input RAM address width.
- OUT_AW, $clog2(NUM_CH*OUT_DIM*OUT_DIM), output RAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to pool all channels
- hold  in  1  backpressure: suppresses new input reads while high
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last channel has been written
- err  out  1  sticky: engine all_done disagreed with the internal count
- ch_idx  out  $clog2(NUM_CH) (min 1)  channel currently being processed
- rd_en  out  1  input RAM read strobe
- rd_addr  out  IN_AW  input RAM address
- rd_data  in  8 signed  input RAM data, valid the cycle after rd_en
- eng_rst  out  1  engine reset
- eng_valid_in  out  1  to engine valid_in
- eng_pixel_in  out  8 signed  to engine pixel_in
- eng_valid_out  in  1  from engine valid_out
- eng_pixel_out  in  8 signed  from engine pixel_out
- eng_all_done  in  1  from engine all_done
- wr_en  out  1  output RAM write strobe
- wr_addr  out  OUT_AW  output RAM address
- wr_data  out  8 signed  output RAM data

Behaviour:
- Reset: state IDLE. These outputs are 0: busy, done, err, ch_idx, rd_en, rd_addr, eng_valid_in, eng_pixel_in, wr_en, wr_addr, wr_data. eng_rst = 1 while rst is high (eng_rst = rst OR state==CLR). Reset mid-operation aborts immediately; no further reads or writes occur.
- States: IDLE, CLR, STREAM, DRAIN, DONE.
- IDLE: start -> CLR with ch_idx=0. start is ignored in all other states.
- CLR (1 cycle):
  - eng_rst=1.
  - Clear the per-channel read counter rd_cnt and write counter wr_cnt.
  - -> STREAM.
- STREAM:
  - Each cycle with hold=0: rd_en=1, rd_addr = ch_idx*MAP_WIDTH^2 + rd_cnt, rd_cnt++.
  - hold=1: rd_en=0 and counters hold.
  - When the read with rd_cnt = MAP_WIDTH^2-1 issues -> DRAIN.
- Engine feed: eng_valid_in and eng_pixel_in equal rd_en and rd_data delayed by one register stage. This aligns with RAM latency, so eng_pixel_in = rd_data when eng_valid_in=1. A read already in flight when hold rises still completes.
- Output path (registered, 1 cycle):
  - wr_en = eng_valid_out (delayed), wr_data = eng_pixel_out (delayed).
  - wr_addr = ch_idx*OUT_DIM^2 + wr_cnt.
  - wr_cnt increments per write.
- DRAIN:
  - When wr_en=1 and wr_cnt == OUT_DIM^2-1:
    - if ch_idx == NUM_CH-1 -> DONE;
    - else ch_idx++ and -> CLR.
  - hold has no effect in DRAIN.
- DONE (1 cycle): done=1, busy=0 next cycle, -> IDLE. ch_idx returns to 0.
- Latency: with hold held low, the last read issues at cycle k. Then eng_valid_in is at k+1, eng_valid_out at k+2, wr_en at k+3.
  - Per-channel period = MAP_WIDTH^2 + 4 cycles.
  - done pulses exactly NUM_CH*(MAP_WIDTH^2+4)+1 cycles after the start cycle.
- err:
  - Set if eng_all_done rises on a cycle when the final write of the channel is not pending.
  - Set if the final write occurs without eng_all_done rising within 1 cycle.
  - Cleared only by rst.
- Addresses never exceed NUM_CH*MAP_WIDTH^2-1 (input) or NUM_CH*OUT_DIM^2-1 (output).
- Signed data passes through unmodified.

Test Plan:
- MAP_WIDTH=4, NUM_CH=2, input RAM[i] = i-16 (signed), start at cycle 0, hold=0.
  - Outputs: ch0 writes addr 0..3 = {-11,-9,-3,-1}; ch1 writes addr 4..7 = {5,7,13,15}.
  - done at cycle 41; err=0.
- All inputs -128 except one pixel -1 per 2x2 window -> every output is -1 (signed compare check).
- hold toggled 1-0-1-0 during STREAM -> same RAM contents as the no-hold run.
  - done is delayed by exactly the number of held STREAM cycles.
  - rd_en never asserts while hold=1.
- Between channels: eng_rst=1 for exactly one cycle before each channel's first rd_en. No rd_en or wr_en occurs in that cycle.
- rst asserted mid-STREAM of ch1 -> next cycle: busy=0, rd_en=0, wr_en=0, ch_idx=0. A following start reruns all channels correctly.
- start pulsed while busy -> ignored, no extra done. An engine model that fires all_done one output early -> err=1 and stays set.

Source files
------------

// File: rtl/maxpool_scheduler.sv
// maxpool_scheduler: walks NUM_CH feature maps through one shared
// maxpool engine, from the input feature RAM to the output RAM.
module maxpool_scheduler #(
    parameter int MAP_WIDTH = 28,
    parameter int OUT_DIM   = MAP_WIDTH / 2,
    parameter int NUM_CH    = 6,
    parameter int IN_AW     = $clog2(NUM_CH * MAP_WIDTH * MAP_WIDTH),
    parameter int OUT_AW    = $clog2(NUM_CH * OUT_DIM * OUT_DIM),
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CHW-1:0]           ch_idx,
    output logic                     rd_en,
    output logic [IN_AW-1:0]         rd_addr,
    input  logic signed [7:0]        rd_data,
    output logic                     eng_rst,
    output logic                     eng_valid_in,
    output logic signed [7:0]        eng_pixel_in,
    input  logic                     eng_valid_out,
    input  logic signed [7:0]        eng_pixel_out,
    input  logic                     eng_all_done,
    output logic                     wr_en,
    output logic [OUT_AW-1:0]        wr_addr,
    output logic signed [7:0]        wr_data
);

    localparam int PIX  = MAP_WIDTH * MAP_WIDTH;
    localparam int OPIX = OUT_DIM * OUT_DIM;

    localparam logic [IN_AW-1:0]  PIX_W  = IN_AW'(PIX);
    localparam logic [IN_AW-1:0]  PLAST  = IN_AW'(PIX - 1);
    localparam logic [OUT_AW-1:0] OPIX_W = OUT_AW'(OPIX);
    localparam logic [OUT_AW-1:0] OLAST  = OUT_AW'(OPIX - 1);
    localparam logic [CHW-1:0]    CLAST  = CHW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [IN_AW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [IN_AW-1:0]    rd_base_q, rd_base_d;
    logic [OUT_AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [OUT_AW-1:0]   wr_base_q, wr_base_d;
    logic [OUT_AW-1:0]   eng_cnt_q, eng_cnt_d;
    logic                seen_q, seen_d;
    logic                err_q, err_d;
    logic                all_done_q;
    logic                vin_q;
    logic                wr_en_q, wr_en_d;
    logic signed [7:0]   wr_data_q;

    logic active;
    logic rd_go;
    logic rise;
    logic final_out;
    logic final_wr;

    assign active    = (state_q == STREAM) || (state_q == DRAIN);
    assign rd_go     = (state_q == STREAM) && !hold && !rst;
    assign rise      = eng_all_done && !all_done_q;
    assign final_out = active && eng_valid_out && (eng_cnt_q == OLAST);
    assign final_wr  = wr_en_q && (wr_cnt_q == OLAST);
    assign wr_en_d   = active && eng_valid_out;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rd_cnt_d  = rd_cnt_q;
        rd_base_d = rd_base_q;
        wr_cnt_d  = wr_cnt_q + OUT_AW'(wr_en_q);
        wr_base_d = wr_base_q;
        eng_cnt_d = eng_cnt_q + OUT_AW'(wr_en_d);
        seen_d    = seen_q || (rise && (final_out || final_wr));
        // all_done must rise with the last output or its write
        err_d     = err_q
                  || (rise && !(final_out || final_wr))
                  || (final_wr && !(seen_q || rise));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLR;
                    ch_d      = '0;
                    rd_base_d = '0;
                    wr_base_d = '0;
                end
            end
            CLR: begin
                rd_cnt_d  = '0;
                wr_cnt_d  = '0;
                eng_cnt_d = '0;
                seen_d    = 1'b0;
                state_d   = STREAM;
            end
            STREAM: begin
                if (rd_go) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == PLAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (final_wr) begin
                    if (ch_q == CLAST) begin
                        state_d = DONE;
                    end else begin
                        state_d   = CLR;
                        ch_d      = ch_q + 1'b1;
                        rd_base_d = rd_base_q + PIX_W;
                        wr_base_d = wr_base_q + OPIX_W;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                ch_d      = '0;
                rd_base_d = '0;
                wr_base_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            rd_cnt_q   <= '0;
            rd_base_q  <= '0;
            wr_cnt_q   <= '0;
            wr_base_q  <= '0;
            eng_cnt_q  <= '0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            all_done_q <= 1'b0;
            vin_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_base_q  <= rd_base_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_base_q  <= wr_base_d;
            eng_cnt_q  <= eng_cnt_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            all_done_q <= eng_all_done;
            vin_q      <= rd_go;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= eng_valid_out ? eng_pixel_out : wr_data_q;
        end
    end

    // RAM data arrives one cycle after the strobe, alongside vin_q
    assign eng_valid_in = vin_q;
    assign eng_pixel_in = vin_q ? rd_data : 8'sd0;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign ch_idx  = ch_q;
    assign rd_en   = rd_go;
    assign rd_addr = rd_base_q + rd_cnt_q;
    assign eng_rst = rst || (state_q == CLR);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_base_q + wr_cnt_q;
    assign wr_data = wr_data_q;

endmodule
